// File: rtl/machine_timer_if.sv
// ---------------------------------------------------------------------------
// machine_timer_if
//
// Peripheral bus bundle used to reach the machine timer registers.
//
// Signals:
//   bus_sel   - request valid this cycle (master -> slave)
//   bus_we    - 1 = write, 0 = read (master -> slave)
//   bus_addr  - byte offset, bits [1:0] ignored (master -> slave)
//   bus_wdata - full-word write data (master -> slave)
//   bus_rdata - read data, valid while bus_ack is high, else 0 (slave -> master)
//   bus_ack   - one-cycle completion pulse (slave -> master)
// ---------------------------------------------------------------------------
interface machine_timer_if;
    logic        bus_sel;
    logic        bus_we;
    logic [4:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_sel,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        input  bus_rdata,
        input  bus_ack
    );

    modport slave (
        input  bus_sel,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        output bus_rdata,
        output bus_ack
    );
endinterface

// File: rtl/machine_timer.sv
// ---------------------------------------------------------------------------
// machine_timer
//
// Memory-mapped RISC-V machine timer. Holds a free-running 64-bit mtime
// counter and a 64-bit mtimecmp register and drives timer_int (MIP.MTIP)
// while the timer is enabled and mtime >= mtimecmp.
//
// Ports:
//   clk       - single clock
//   reset_n   - asynchronous active-low reset
//   bus       - machine_timer_if.slave register access port
//   timer_int - registered machine timer interrupt level
//
// Register map (byte offsets):
//   0x00 MTIME_LO, 0x04 MTIME_HI (shadow), 0x08 MTIMECMP_LO,
//   0x0C MTIMECMP_HI, 0x10 CTRL (bit0 EN, bits[8+PRESCALE_W-1:8] DIV).
//
// Build option:
//   MTIMER_PRESCALER_EN - when defined, CTRL.DIV and the prescale counter are
//                         implemented; otherwise every enabled cycle is a tick.
// ---------------------------------------------------------------------------
module machine_timer #(
    parameter logic [63:0] CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF,
    parameter int          PRESCALE_W = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    machine_timer_if.slave  bus,
    output logic            timer_int
);

    localparam logic [2:0] IDX_MTIME_LO = 3'd0;
    localparam logic [2:0] IDX_MTIME_HI = 3'd1;
    localparam logic [2:0] IDX_CMP_LO   = 3'd2;
    localparam logic [2:0] IDX_CMP_HI   = 3'd3;
    localparam logic [2:0] IDX_CTRL     = 3'd4;

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [31:0] shadow_q, shadow_d;
    logic        en_q, en_d;
    logic        ack_q;
    logic [31:0] rdata_q, rdata_d;
    logic        timerInt_q, timerInt_d;

    logic [2:0]            regIdx;
    logic                  wrEn;
    logic                  rdEn;
    logic                  presFire;
    logic                  tick;
    logic [PRESCALE_W-1:0] divField;
    logic [31:0]           ctrlRead;
    logic [31:0]           readVal;
    logic                  unused_addr_bits;

    assign regIdx           = bus.bus_addr[4:2];
    assign unused_addr_bits = &{1'b0, bus.bus_addr[1:0]};
    assign wrEn             = bus.bus_sel && bus.bus_we;
    assign rdEn             = bus.bus_sel && !bus.bus_we;

`ifdef MTIMER_PRESCALER_EN
    logic [PRESCALE_W-1:0] div_q, div_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;

    assign divField = div_q;
    assign presFire = (pcnt_q == div_q);

    // Prescale counter runs only while enabled; a CTRL write restarts the
    // divide period so the first tick lands DIV+1 cycles after the write.
    always_comb begin
        div_d  = div_q;
        pcnt_d = pcnt_q;
        if (wrEn && (regIdx == IDX_CTRL)) begin
            div_d  = bus.bus_wdata[8 +: PRESCALE_W];
            pcnt_d = '0;
        end else if (en_q) begin
            pcnt_d = presFire ? '0 : pcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q  <= '0;
            pcnt_q <= '0;
        end else begin
            div_q  <= div_d;
            pcnt_q <= pcnt_d;
        end
    end
`else
    assign divField = '0;
    assign presFire = 1'b1;
`endif

    assign tick     = en_q && presFire;
    assign ctrlRead = 32'(en_q) | (32'(divField) << 8);

    // Read mux over the pre-edge register state.
    always_comb begin
        readVal = '0;
        case (regIdx)
            IDX_MTIME_LO: readVal = mtime_q[31:0];
            IDX_MTIME_HI: readVal = shadow_q;
            IDX_CMP_LO:   readVal = mtimecmp_q[31:0];
            IDX_CMP_HI:   readVal = mtimecmp_q[63:32];
            IDX_CTRL:     readVal = ctrlRead;
            default:      readVal = '0;
        endcase
    end

    // A software write to either mtime half wins over the tick for the whole
    // 64-bit counter, so no carry leaks into the half that was not written.
    // Reading MTIME_LO latches the matching high word for a tear-free read.
    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        shadow_d   = shadow_q;
        en_d       = en_q;
        if (wrEn && (regIdx == IDX_MTIME_LO)) begin
            mtime_d[31:0] = bus.bus_wdata;
        end else if (wrEn && (regIdx == IDX_MTIME_HI)) begin
            mtime_d[63:32] = bus.bus_wdata;
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
        if (wrEn && (regIdx == IDX_CMP_LO)) begin
            mtimecmp_d[31:0] = bus.bus_wdata;
        end
        if (wrEn && (regIdx == IDX_CMP_HI)) begin
            mtimecmp_d[63:32] = bus.bus_wdata;
        end
        if (wrEn && (regIdx == IDX_CTRL)) begin
            en_d = bus.bus_wdata[0];
        end
        if (rdEn && (regIdx == IDX_MTIME_LO)) begin
            shadow_d = mtime_q[63:32];
        end
        rdata_d    = rdEn ? readVal : 32'd0;
        timerInt_d = en_q && (mtime_q >= mtimecmp_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mtime_q    <= '0;
            mtimecmp_q <= CMP_RESET;
            shadow_q   <= '0;
            en_q       <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            timerInt_q <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            shadow_q   <= shadow_d;
            en_q       <= en_d;
            ack_q      <= bus.bus_sel;
            rdata_q    <= rdata_d;
            timerInt_q <= timerInt_d;
        end
    end

    assign bus.bus_rdata = rdata_q;
    assign bus.bus_ack   = ack_q;
    assign timer_int     = timerInt_q;

endmodule

// File: tb/tb_machine_timer.sv
// ---------------------------------------------------------------------------
// tb_machine_timer
//
// Self-checking bench for machine_timer. A reference model describes mtime
// as "value at the last disturbance plus elapsed enabled cycles" and predicts
// read data, ack and timer_int for every bus cycle.
// ---------------------------------------------------------------------------
module tb_machine_timer;

    localparam logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk;
    logic reset_n;
    logic timerInt;

    machine_timer_if bus ();

    machine_timer #(
        .CMP_RESET (CMP_RST),
        .PRESCALE_W(8)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .timer_int(timerInt)
    );

    // Free-running 100 MHz-style clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int testsRun;
    int testsFailed;

    // Reference model state: mBase is the mtime value right after edge
    // mBaseEdge; while enabled mtime advances by one per edge from there.
    logic [63:0] mBase;
    logic [63:0] mCmp;
    logic [31:0] mShadow;
    logic [31:0] mCtrl;
    logic        mEn;
    int          mBaseEdge;
    int          edgeNo;
    bit          modelOn;

    typedef struct {
        logic        sel;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        expAck;
        logic [31:0] expRdata;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [63:0] mtimeAt(int j);
        if (mEn) return mBase + 64'(j - mBaseEdge);
        return mBase;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkCond(input string name, input logic ok, input logic [63:0] actual);
        testsRun++;
        if (ok !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, outside required range", name, actual);
        end
    endtask

    task automatic modelReset();
        mBase     = 64'd0;
        mCmp      = CMP_RST;
        mShadow   = 32'd0;
        mCtrl     = 32'd0;
        mEn       = 1'b0;
        mBaseEdge = edgeNo;
    endtask

    // One bus cycle: drive, let the edge happen, advance the model, compare.
    task automatic applyStimulus(input logic sel, input logic we, input logic [4:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] rd,
                                 output logic ack);
        logic [63:0] pre;
        logic [63:0] post;
        logic [31:0] expRd;
        logic        expInt;
        logic [2:0]  idx;
        bus.bus_sel   = sel;
        bus.bus_we    = we;
        bus.bus_addr  = addr;
        bus.bus_wdata = wdata;
        @(posedge clk);
        edgeNo++;
        pre    = mtimeAt(edgeNo - 1);
        idx    = addr[4:2];
        expRd  = 32'd0;
        if (sel && !we) begin
            case (idx)
                3'd0:    expRd = pre[31:0];
                3'd1:    expRd = mShadow;
                3'd2:    expRd = mCmp[31:0];
                3'd3:    expRd = mCmp[63:32];
                3'd4:    expRd = mCtrl;
                default: expRd = 32'd0;
            endcase
        end
        expInt = mEn && (pre >= mCmp);
        if (sel && !we && idx == 3'd0) mShadow = pre[63:32];
        if (sel && we) begin
            case (idx)
                3'd0: begin mBase = {pre[63:32], wdata}; mBaseEdge = edgeNo; end
                3'd1: begin mBase = {wdata, pre[31:0]}; mBaseEdge = edgeNo; end
                3'd2: mCmp[31:0]  = wdata;
                3'd3: mCmp[63:32] = wdata;
                3'd4: begin
                    post      = mtimeAt(edgeNo);
                    mBase     = post;
                    mBaseEdge = edgeNo;
                    mEn       = wdata[0];
`ifdef MTIMER_PRESCALER_EN
                    mCtrl     = {16'd0, wdata[15:8], 7'd0, wdata[0]};
`else
                    mCtrl     = {31'd0, wdata[0]};
`endif
                end
                default: ;
            endcase
        end
        #1;
        rd  = bus.bus_rdata;
        ack = bus.bus_ack;
        if (modelOn) begin
            checkOutput("model_ack", {63'd0, ack}, {63'd0, sel});
            checkOutput("model_rdata", {32'd0, rd}, {32'd0, expRd});
            checkOutput("model_timer_int", {63'd0, timerInt}, {63'd0, expInt});
        end
    endtask

    task automatic busWrite(input logic [4:0] addr, input logic [31:0] data);
        logic [31:0] rd;
        logic        ack;
        applyStimulus(1'b1, 1'b1, addr, data, rd, ack);
    endtask

    task automatic busRead(input logic [4:0] addr, output logic [31:0] data);
        logic ack;
        applyStimulus(1'b1, 1'b0, addr, 32'd0, data, ack);
    endtask

    task automatic idle(input int n);
        logic [31:0] rd;
        logic        ack;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, rd, ack);
    endtask

    task automatic doReset();
        reset_n       = 1'b0;
        bus.bus_sel   = 1'b0;
        bus.bus_we    = 1'b0;
        bus.bus_addr  = 5'd0;
        bus.bus_wdata = 32'd0;
        repeat (2) @(negedge clk);
        modelReset();
        reset_n = 1'b1;
        #1;
    endtask

    // Hard stop in case the bench ever stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] rd, rd1, rd2, rd3;
        logic        a1, a2, a3;
        int          n;
        logic [63:0] cur;
        int          op;

        testsRun    = 0;
        testsFailed = 0;
        edgeNo      = 0;
        modelOn     = 1'b1;
        modelReset();

        // ---------------- Reset values ----------------
        doReset();
        checkOutput("reset_ack", {63'd0, bus.bus_ack}, 64'd0);
        checkOutput("reset_rdata", {32'd0, bus.bus_rdata}, 64'd0);
        checkOutput("reset_timer_int", {63'd0, timerInt}, 64'd0);

        // ---------------- Table-driven register access ----------------
        vecs.push_back('{1'b1, 1'b0, 5'h08, 32'h0,     1'b1, 32'hFFFF_FFFF, "cmp_lo_reset"});
        vecs.push_back('{1'b1, 1'b0, 5'h0C, 32'h0,     1'b1, 32'hFFFF_FFFF, "cmp_hi_reset"});
        vecs.push_back('{1'b1, 1'b0, 5'h10, 32'h0,     1'b1, 32'h0,         "ctrl_reset"});
        vecs.push_back('{1'b1, 1'b0, 5'h00, 32'h0,     1'b1, 32'h0,         "mtime_lo_reset"});
        vecs.push_back('{1'b1, 1'b0, 5'h04, 32'h0,     1'b1, 32'h0,         "mtime_hi_reset"});
        vecs.push_back('{1'b1, 1'b1, 5'h08, 32'h1234,  1'b1, 32'h0,         "cmp_lo_write"});
        vecs.push_back('{1'b1, 1'b0, 5'h0B, 32'h0,     1'b1, 32'h1234,      "cmp_lo_lowbits"});
        vecs.push_back('{1'b1, 1'b1, 5'h1C, 32'hDEAD,  1'b1, 32'h0,         "unmapped_write"});
        vecs.push_back('{1'b1, 1'b0, 5'h1C, 32'h0,     1'b1, 32'h0,         "unmapped_read"});
        vecs.push_back('{1'b1, 1'b1, 5'h04, 32'hABCD,  1'b1, 32'h0,         "mtime_hi_write"});
        vecs.push_back('{1'b1, 1'b0, 5'h04, 32'h0,     1'b1, 32'h0,         "hi_reads_shadow"});
        vecs.push_back('{1'b1, 1'b0, 5'h00, 32'h0,     1'b1, 32'h0,         "lo_read_latch"});
        vecs.push_back('{1'b1, 1'b0, 5'h04, 32'h0,     1'b1, 32'hABCD,      "hi_after_latch"});
        vecs.push_back('{1'b0, 1'b0, 5'h00, 32'h0,     1'b0, 32'h0,         "idle_no_ack"});
        foreach (vecs[i]) begin
            logic [31:0] vr;
            logic        va;
            applyStimulus(vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].wdata, vr, va);
            checkOutput({"tbl_ack_", vecs[i].name}, {63'd0, va}, {63'd0, vecs[i].expAck});
            checkOutput({"tbl_rdata_", vecs[i].name}, {32'd0, vr}, {32'd0, vecs[i].expRdata});
        end

        // ---------------- Counting after enable ----------------
        doReset();
        busWrite(5'h10, 32'h1);
        idle(10);
        busRead(5'h00, rd);
        checkCond("count_10", (rd >= 32'd9) && (rd <= 32'd11), {32'd0, rd});
        checkOutput("count_no_int", {63'd0, timerInt}, 64'd0);

        // ---------------- Compare fire and clear ----------------
        doReset();
        busWrite(5'h0C, 32'h0);
        busWrite(5'h08, 32'd20);
        busWrite(5'h10, 32'h1);
        n = 0;
        while (!timerInt && n < 60) begin
            idle(1);
            n++;
        end
        checkOutput("int_rise_cycle", 64'(n), 64'd21);
        busWrite(5'h08, 32'hFFFF_FFFF);
        checkOutput("int_held_during_ack", {63'd0, timerInt}, 64'd1);
        idle(1);
        checkOutput("int_cleared", {63'd0, timerInt}, 64'd0);

        // ---------------- Carry and shadow ----------------
        doReset();
        busWrite(5'h04, 32'h0);
        busWrite(5'h00, 32'hFFFF_FFFE);
        busWrite(5'h10, 32'h1);
        idle(3);
        busRead(5'h00, rd);
        checkCond("carry_lo_wrapped", rd < 32'hFFFF_FFFE, {32'd0, rd});
        busRead(5'h04, rd);
        checkOutput("carry_hi_shadow", {32'd0, rd}, 64'd1);

        // ---------------- Write versus tick collision ----------------
        busWrite(5'h00, 32'd5);
        busRead(5'h00, rd);
        checkOutput("collision_lo", {32'd0, rd}, 64'd5);

        // ---------------- Bus protocol back-to-back ----------------
        doReset();
        busWrite(5'h10, 32'h1);
        idle(4);
        applyStimulus(1'b1, 1'b0, 5'h00, 32'h0, rd1, a1);
        applyStimulus(1'b1, 1'b0, 5'h14, 32'h0, rd2, a2);
        applyStimulus(1'b1, 1'b0, 5'h08, 32'h0, rd3, a3);
        checkOutput("b2b_ack", {61'd0, a1, a2, a3}, 64'd7);
        checkOutput("b2b_lo", {32'd0, rd1}, 64'd4);
        checkOutput("b2b_unmapped", {32'd0, rd2}, 64'd0);
        checkOutput("b2b_cmp_lo", {32'd0, rd3}, {32'd0, CMP_RST[31:0]});
        idle(1);
        checkOutput("b2b_ack_drop", {63'd0, bus.bus_ack}, 64'd0);
        checkOutput("b2b_rdata_zero", {32'd0, bus.bus_rdata}, 64'd0);

        // ---------------- Prescaler ----------------
        doReset();
        modelOn = 1'b0;
        busWrite(5'h10, 32'h0000_0301);
        idle(40);
        busRead(5'h00, rd);
`ifdef MTIMER_PRESCALER_EN
        checkOutput("prescale_mtime", {32'd0, rd}, 64'd10);
`else
        checkOutput("prescale_mtime", {32'd0, rd}, 64'd40);
`endif
        busRead(5'h10, rd);
`ifdef MTIMER_PRESCALER_EN
        checkOutput("prescale_ctrl", {32'd0, rd}, 64'h301);
`else
        checkOutput("prescale_ctrl", {32'd0, rd}, 64'h1);
`endif
        modelOn = 1'b1;

        // ---------------- Reset mid-transaction ----------------
        doReset();
        bus.bus_sel  = 1'b1;
        bus.bus_we   = 1'b0;
        bus.bus_addr = 5'h08;
        @(posedge clk);
        #1;
        checkOutput("pre_reset_ack", {63'd0, bus.bus_ack}, 64'd1);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("async_reset_ack", {63'd0, bus.bus_ack}, 64'd0);
        checkOutput("async_reset_rdata", {32'd0, bus.bus_rdata}, 64'd0);
        doReset();

        // ---------------- Randomized traffic against the model ----------------
        busWrite(5'h10, 32'h1);
        for (int i = 0; i < 400; i++) begin
            op  = $urandom_range(0, 11);
            cur = mtimeAt(edgeNo);
            case (op)
                0, 1, 2: idle(1);
                3:       busRead(5'({$urandom_range(0, 7), 2'($urandom_range(0, 3))}), rd);
                4:       busRead(5'h00, rd);
                5:       busRead(5'h04, rd);
                6:       busWrite(5'h00, ($urandom_range(0, 1) == 1) ? $urandom
                                                                     : 32'hFFFF_FFF0);
                7:       busWrite(5'h04, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF
                                                                     : cur[63:32]);
                8:       busWrite(5'h0C, cur[63:32]);
                9:       busWrite(5'h08, cur[31:0] + 32'($urandom_range(0, 30)));
                10:      busWrite(5'h10, ($urandom_range(0, 3) == 0) ? 32'h0 : 32'h1);
                default: busWrite(5'h18, $urandom);
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
